// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl
//   Shares one overlapping "01010" serial detector between two word requesters.
//   A requester is granted by round-robin arbitration. Its word is captured on
//   the grant edge and shifted into the detector MSB-first, one bit per clock.
//   Detections are counted per word, and a done pulse closes each word.
//
//   Build option: SEQ_STREAM_CTRL_FIXED_PRIO_EN
//     defined   -> fixed priority, req0 always wins.
//     undefined -> round-robin; the pointer flips to the other requester
//                  after every word.
//
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     req0/req1       requests, held until the matching grant
//     data0/data1     words, sampled only on the grant edge
//     gnt0/gnt1       one-cycle grant pulses
//     busy            high from the cycle after grant through DONE
//     owner           current/last granted requester
//     sout            serial bit consumed this cycle (0 outside SHIFT)
//     det             registered detection pulse
//     match_cnt       saturating detection count for the current/last word
//     done            one-cycle completion pulse
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration happens here
//   SHIFT | serialising the captured word into the detector
//   DONE  | one-cycle completion; det may still show the last bit's hit
module seq_stream_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          busy,
  output logic          owner,
  output logic          sout,
  output logic          det,
  output logic [CW-1:0] match_cnt,
  output logic          done
);

  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Detector states name the longest matched prefix of "01010".
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} det_state_t;

  state_t          state, state_next;
  det_state_t      dstate, dstate_next;
  logic [W-1:0]    shreg;
  logic [BW-1:0]   bitcnt;
  logic            grant_any;
  logic            grant_sel;
  logic            hit;
`ifndef SEQ_STREAM_CTRL_FIXED_PRIO_EN
  logic            ptr;
`endif

  always_comb begin
    state_next  = state;
    dstate_next = dstate;
    grant_any   = 1'b0;
    grant_sel   = 1'b0;
    hit         = 1'b0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    sout        = (state == SHIFT) ? shreg[W-1] : 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_any  = 1'b1;
`ifdef SEQ_STREAM_CTRL_FIXED_PRIO_EN
          grant_sel  = ~req0;
`else
          // ptr=1 favours req1; otherwise req0 wins when present.
          grant_sel  = ptr ? req1 : ~req0;
`endif
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        case (dstate)
          S0:      dstate_next = sout ? S0 : S1;
          S1:      dstate_next = sout ? S2 : S1;
          S2:      dstate_next = sout ? S0 : S3;
          S3:      dstate_next = sout ? S4 : S1;
          S4:      dstate_next = sout ? S0 : S5;
          S5:      dstate_next = sout ? S4 : S1;  // overlap keeps "0101" / "0"
          default: dstate_next = S0;
        endcase
        hit = (dstate_next == S5);
        if (bitcnt == BW'(W - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dstate    <= S0;
      shreg     <= '0;
      bitcnt    <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      owner     <= 1'b0;
      det       <= 1'b0;
      match_cnt <= '0;
`ifndef SEQ_STREAM_CTRL_FIXED_PRIO_EN
      ptr       <= 1'b0;
`endif
    end else begin
      state <= state_next;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            gnt0      <= ~grant_sel;
            gnt1      <= grant_sel;
            shreg     <= grant_sel ? data1 : data0;
            owner     <= grant_sel;
            bitcnt    <= '0;
            match_cnt <= '0;
            dstate    <= S0;
            det       <= 1'b0;
          end
        end
        SHIFT: begin
          dstate <= dstate_next;
          shreg  <= {shreg[W-2:0], 1'b0};
          bitcnt <= bitcnt + BW'(1);
          det    <= hit;
          if (hit && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CW'(1);
          end
        end
        DONE: begin
          det <= 1'b0;
`ifndef SEQ_STREAM_CTRL_FIXED_PRIO_EN
          ptr <= ~owner;
`endif
        end
        default: begin
          det <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
module tb_seq_stream_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;

  logic         gnt0, gnt1, busy, owner, sout, det, done;
  logic [3:0]   match_cnt;
  logic         gnt0_s, gnt1_s, busy_s, owner_s, sout_s, det_s, done_s;
  logic [0:0]   match_cnt_s;

  seq_stream_ctrl #(.W(W), .CW(4)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .owner(owner), .sout(sout),
    .det(det), .match_cnt(match_cnt), .done(done)
  );

  // Same stimulus, 1-bit counter: exercises saturation.
  seq_stream_ctrl #(.W(W), .CW(1)) u_sat (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0_s), .gnt1(gnt1_s), .busy(busy_s), .owner(owner_s), .sout(sout_s),
    .det(det_s), .match_cnt(match_cnt_s), .done(done_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic owner;
    int   gap;
  } gexp_t;

  typedef struct {
    logic         owner;
    int           mc;
    int           mc1;
    int           detc;
    logic [W-1:0] bits;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           cyc = 0;
  int           last_g = 0;
  int           nbits = 0;
  int           detc = 0;
  int           detc1 = 0;
  logic [W-1:0] bits = '0;
  gexp_t        g;
  dexp_t        d;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nbits = 0; detc = 0; detc1 = 0; bits = '0;
    end else begin
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", int'(gnt0 && gnt1), 0);
        chk("sat_gnt_same", int'({gnt0_s, gnt1_s}), int'({gnt0, gnt1}));
        chk("owner_at_grant", int'(owner), int'(gnt1));
        if (gq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_grant actual=gnt%0d required=none", gnt1);
        end else begin
          g = gq.pop_front();
          chk("grant_owner", int'(gnt1), int'(g.owner));
          if (g.gap >= 0) chk("grant_gap", cyc - last_g, g.gap);
        end
        last_g = cyc;
        nbits = 0; detc = 0; detc1 = 0; bits = '0;
      end
      if (busy && !done) begin
        bits = {bits[W-2:0], sout};
        nbits++;
      end
      if (busy && det)   detc++;
      if (busy && det_s) detc1++;
      if (done) begin
        chk("done_busy", int'(busy), 1);
        chk("sat_done_same", int'(done_s), 1);
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=done required=none");
        end else begin
          d = dq.pop_front();
          chk("done_owner", int'(owner), int'(d.owner));
          chk("done_nbits", nbits, W);
          chk("done_bits", int'(bits), int'(d.bits));
          chk("done_match_cnt", int'(match_cnt), d.mc);
          chk("done_match_cnt_sat", int'(match_cnt_s), d.mc1);
          chk("done_det_pulses", detc, d.detc);
          chk("done_det_pulses_sat", detc1, d.detc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_word(input logic o, input logic [W-1:0] w, input int mc,
                           input int mc1, input int dc, input int gap);
    gexp_t ge;
    dexp_t de;
    ge.owner = o; ge.gap = gap;
    de.owner = o; de.mc = mc; de.mc1 = mc1; de.detc = dc; de.bits = w;
    gq.push_back(ge);
    dq.push_back(de);
  endtask

  task automatic wait_gnt(input int k);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if ((k == 0 && gnt0) || (k == 1 && gnt1)) ok = 1;
    end
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_any_gnt();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) ok = 1;
    end
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, int'({gnt0, gnt1}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_det"}, int'(det), 0);
    chk({tag, "_sout"}, int'(sout), 0);
    chk({tag, "_owner"}, int'(owner), 0);
    chk({tag, "_match_cnt"}, int'(match_cnt), 0);
    chk({tag, "_sat_match_cnt"}, int'(match_cnt_s), 0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_busy", int'(busy), 0);

    // Word 1: 0x54 -> bits 0,1,0,1,0,1,0,0, detections after E5 and E7.
    push_word(1'b0, 8'h54, 2, 1, 2, -1);
    data0 = 8'h54; req0 = 1'b1;
    wait_gnt(0);
    req0 = 1'b0;
    wait_done();

    // Word 2: 0xFF from req1, data changed after its grant.
    push_word(1'b1, 8'hFF, 0, 0, 0, -1);
    data1 = 8'hFF; req1 = 1'b1;
    wait_gnt(1);
    req1 = 1'b0; data1 = 8'h00;
    repeat (3) @(negedge clk);
    // Word 3 requested while busy: granted exactly W+2 cycles after word 2.
    push_word(1'b0, 8'h54, 2, 1, 2, 10);
    data0 = 8'h54; req0 = 1'b1;
    wait_gnt(0);
    req0 = 1'b0; data0 = 8'hFF;
    wait_done();

    // Both requests held: pointer after word 3 favours requester 1.
    data0 = 8'h54; data1 = 8'hFF;
`ifdef SEQ_STREAM_CTRL_FIXED_PRIO_EN
    push_word(1'b0, 8'h54, 2, 1, 2, -1);
    push_word(1'b0, 8'h54, 2, 1, 2, 10);
    push_word(1'b0, 8'h54, 2, 1, 2, 10);
    push_word(1'b0, 8'h54, 2, 1, 2, 10);
`else
    push_word(1'b1, 8'hFF, 0, 0, 0, -1);
    push_word(1'b0, 8'h54, 2, 1, 2, 10);
    push_word(1'b1, 8'hFF, 0, 0, 0, 10);
    push_word(1'b0, 8'h54, 2, 1, 2, 10);
`endif
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) wait_any_gnt();
    req0 = 1'b0; req1 = 1'b0;
    wait_done();

    // Abort: reset after E3 of a word; no done may follow.
    begin
      gexp_t ga;
      ga.owner = 1'b0; ga.gap = -1;
      gq.push_back(ga);
    end
    data0 = 8'h54; req0 = 1'b1;
    wait_gnt(0);
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("after_rst_idle", int'(busy), 0);

    push_word(1'b0, 8'h54, 2, 1, 2, -1);
    data0 = 8'h54; req0 = 1'b1;
    wait_gnt(0);
    req0 = 1'b0;
    wait_done();

    repeat (15) @(negedge clk);
    chk("grant_queue_empty", gq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
